// File: rtl/fifo_sync_flags.sv
// Parametrised synchronous FIFO with occupancy count, almost/full/empty flags,
// sticky overflow/underflow, synchronous flush and optional first-word-fall-through.
module fifo_sync_flags #(
  parameter int unsigned WORD      = 8,
  parameter int unsigned LEN       = 4,
  parameter int unsigned FWFT      = 0,
  parameter int unsigned AFULL_TH  = 3,
  parameter int unsigned AEMPTY_TH = 1,
  localparam int unsigned AW = ($clog2(LEN) > 1) ? $clog2(LEN) : 1,
  localparam int unsigned CW = $clog2(LEN + 1)
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_clear,
  input  logic            i_write,
  input  logic            i_read,
  input  logic [WORD-1:0] i_data,
  output logic [WORD-1:0] o_data,
  output logic            o_valid,
  output logic            o_empty,
  output logic            o_full,
  output logic            o_almost_empty,
  output logic            o_almost_full,
  output logic [CW-1:0]   o_count,
  output logic            o_overflow,
  output logic            o_underflow
);

  logic [WORD-1:0] mem_q [LEN];
  logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d, udf_q, udf_d;
  logic            rd_ok, wr_ok, is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(LEN));

  // Flush wins over both requests; a full FIFO still takes a write if it is also read.
  assign rd_ok = i_read && !is_empty && !i_clear;
  assign wr_ok = i_write && (!is_full || rd_ok) && !i_clear;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (i_clear) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_ok) wp_d = (wp_q == AW'(LEN - 1)) ? '0 : wp_q + AW'(1);
      if (rd_ok) rp_d = (rp_q == AW'(LEN - 1)) ? '0 : rp_q + AW'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (i_write && !wr_ok) ovf_d = 1'b1;
      if (i_read && !rd_ok)  udf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      mem_q <= '{default: '0};
    end else if (wr_ok) begin
      mem_q[wp_q] <= i_data;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign o_data  = mem_q[rp_q];
      assign o_valid = !is_empty;
    end else begin : g_reg
      logic [WORD-1:0] data_q;
      logic            valid_q;
      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_ok;
          if (rd_ok) data_q <= mem_q[rp_q];
        end
      end
      assign o_data  = data_q;
      assign o_valid = valid_q;
    end
  endgenerate

  assign o_empty        = is_empty;
  assign o_full         = is_full;
  assign o_almost_empty = (count_q <= CW'(AEMPTY_TH));
  assign o_almost_full  = (count_q >= CW'(AFULL_TH));
  assign o_count        = count_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = udf_q;

endmodule

// File: doc/fifo_sync_flags.md
# fifo_sync_flags

Parametrised synchronous FIFO that replaces the fixed 8-bit, 4-entry FIFO in the UART/ALU datapath. Width, depth, thresholds and read mode are generic. It adds an occupancy count, almost-full and almost-empty flags, sticky overflow/underflow error flags, and a synchronous flush. A first-word-fall-through mode is selectable per instance. It sits between the UART receiver and the ALU interface, and between the interface and the UART transmitter.

## Interface
- WORD, default 8: data width in bits, ≥ 1.
- LEN, default 4: depth in entries, ≥ 2, any integer, not restricted to powers of two.
- FWFT, default 0: read mode.
  - 0: registered read, 1-cycle latency.
  - 1: first-word-fall-through.
- AFULL_TH, default 3: o_almost_full asserts when count ≥ AFULL_TH. Range 1..LEN.
- AEMPTY_TH, default 1: o_almost_empty asserts when count ≤ AEMPTY_TH. Range 0..LEN-1, and AEMPTY_TH < AFULL_TH.
- Derived widths:
  - AW = max(1, $clog2(LEN)): pointer width.
  - CW = $clog2(LEN+1): count width.

Ports:
- i_clock, input, 1: single clock, rising edge.
- i_reset, input, 1: asynchronous, active-high reset.
- i_clear, input, 1: synchronous flush, active-high.
- i_write, input, 1: write request.
- i_read, input, 1: read request.
- i_data, input, WORD: write data.
- o_data, output, WORD: read data.
- o_valid, output, 1: o_data holds a valid word.
- o_empty, output, 1: count == 0.
- o_full, output, 1: count == LEN.
- o_almost_empty, output, 1: count ≤ AEMPTY_TH.
- o_almost_full, output, 1: count ≥ AFULL_TH.
- o_count, output, CW: current occupancy.
- o_overflow, output, 1: sticky, a write was rejected.
- o_underflow, output, 1: sticky, a read was rejected.

## Operation
- Storage is an array of LEN × WORD, with write pointer wp, read pointer rp and count, all registered.
- Pointers wrap explicitly from LEN-1 to 0. No power-of-two masking.
- Read is accepted (rd_ok) when i_read is high and count ≠ 0.
- Write is accepted (wr_ok) when i_write is high and either count ≠ LEN, or count == LEN and rd_ok (pass-through write on full).
- Simultaneous i_read and i_write:
  - Empty: the write is accepted, the read is rejected, and o_underflow sets.
  - Full: both are accepted and count is unchanged.
  - Otherwise: both are accepted and count is unchanged.
- Count update:
  - +1 on wr_ok only.
  - −1 on rd_ok only.
  - Unchanged on both or neither.
  - Never exceeds LEN and never wraps below 0.
- A rejected write leaves memory, wp and count unchanged and sets o_overflow. A rejected read leaves rp and count unchanged and sets o_underflow.
- Both sticky flags clear only on i_reset or i_clear.
- FWFT=0:
  - On rd_ok, o_data ← mem[rp] on that edge, and o_valid is high for exactly the following cycle.
  - With no rd_ok, o_valid is low and o_data holds its last value.
- FWFT=1:
  - o_data = mem[rp] combinationally and o_valid = !o_empty.
  - rd_ok pops the head. The next word, if any, appears in the same cycle the pointer advances.
- i_clear:
  - Sets wp, rp and count to 0, and clears o_overflow, o_underflow and o_valid.
  - Memory is not cleared.
  - i_clear has priority over i_read and i_write in the same cycle. Neither is accepted, and neither sets an error flag.
- All flags are decoded from the registered count. There is no combinational path from i_read or i_write to the flags.

## Timing
- Reset (asynchronous, i_reset high) produces:
  - Pointers and count at 0, and memory all zeros.
  - o_data=0, o_valid=0, o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0.
  - o_count=0, o_overflow=0, o_underflow=0.
- Reset asserted mid-operation discards contents immediately, without waiting for a clock edge. The first accepted operation is on the first rising edge after i_reset deasserts.
- Write to visibility: data written at edge N is readable via rd_ok at edge N+1. Flags reflect it after edge N.
- FWFT=0 read latency: request sampled at edge N, o_data/o_valid valid from N to N+1.
- FWFT=1 read latency: head visible one cycle after the write that made the FIFO non-empty.
- Throughput: one write and one read per cycle sustained, including at full.
- Level-held requests are honoured once per cycle, so a 5-cycle i_write pulse attempts 5 writes.

## Test plan
- Reset then fill, LEN=4, FWFT=0: write 0x01, 0x02, 0x03, 0x04 on consecutive cycles.
  - After the third write: o_almost_full=1.
  - After the fourth write: o_full=1 and o_count=4.
- Overflow, continuing from the full state: write 0x05 with no read.
  - o_overflow=1, o_count stays 4, and contents are unchanged.
  - Then read 4 times: o_data is 0x01, 0x02, 0x03, 0x04, each with a 1-cycle o_valid pulse one cycle after its request.
- Underflow on empty: read with i_write low sets o_underflow=1 and o_count=0.
  - Then read and write 0x0A in the same cycle: the write is accepted, o_count=1, and the next read returns 0x0A.
- Full pass-through plus wrap: fill with 0x10..0x13, then hold read and write for 6 cycles with data 0x20..0x25.
  - o_count stays 4 and o_overflow stays 0.
  - Outputs are 0x10..0x13 followed by 0x20, 0x21, and the pointers wrap.
- FWFT=1 with LEN=5 (non-power-of-two): write 0x33.
  - Next cycle: o_valid=1 and o_data=0x33 with no read.
  - Fill to 5 and drain: order is preserved across the wrap.
- Clear and async reset:
  - With o_count=3 and both sticky flags set, pulse i_clear together with i_write: o_count=0, flags clear, and no write is accepted.
  - Assert i_reset between clock edges: outputs take their reset values before the next edge.
